shim_abs_sample_concat: RTL and testbench

SHIM_ABS_SAMPLE_CONCAT -- requirements
Module: shim_abs_sample_concat

---
 rtl/shim_sample_pkg.sv | 18 +
 rtl/shim_abs_sat.sv | 31 +++
 rtl/shim_abs_sample_concat.sv | 124 ++++++++++++
 tb/tb_shim_abs_sample_concat.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shim_sample_pkg.sv
// Shared definitions for the sample-concatenation shim.
//   - default channel count, input sample width and output lane width
//   - channel index width carried on sample_channel
//   - control state encoding used by shim_abs_sample_concat
package shim_sample_pkg;

    localparam int unsigned N_CHANNELS_DEF   = 8;
    localparam int unsigned SAMPLE_WIDTH_DEF = 16;
    localparam int unsigned ABS_WIDTH_DEF    = 15;
    localparam int unsigned CHAN_WIDTH       = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_ERROR   = 2'd2
    } state_t;

endpackage

// File: rtl/shim_abs_sat.sv
// Combinational saturated absolute value.
//   sample  : two's-complement input sample
//   abs_val : |sample|, clamped to the all-ones lane value
// The most negative input has no positive counterpart in SAMPLE_WIDTH bits,
// so it lands on the clamp.
module shim_abs_sat
    import shim_sample_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int unsigned ABS_WIDTH    = ABS_WIDTH_DEF
) (
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic [ABS_WIDTH-1:0]    abs_val
);

    logic [SAMPLE_WIDTH-1:0] mag;

    always_comb begin
        mag = sample;
        if (sample[SAMPLE_WIDTH-1]) begin
            mag = ~sample + {{(SAMPLE_WIDTH-1){1'b0}}, 1'b1};
        end
        // Any magnitude bit above the lane width means the lane overflows.
        if (|mag[SAMPLE_WIDTH-1:ABS_WIDTH]) begin
            abs_val = '1;
        end else begin
            abs_val = mag[ABS_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/shim_abs_sample_concat.sv
// Collects one in-order beat per channel, converts each to a saturated
// absolute value and publishes the whole frame as one wide word.
//   clk, resetn        : clock, asynchronous active-low reset
//   enable             : high collects frames, low returns to idle
//   sample_valid/data/channel, sample_ready : upstream beat handshake
//   abs_sample_concat  : published frame, channel i in lane i
//   concat_valid       : one-cycle pulse when abs_sample_concat updates
//   err_sequence       : sticky out-of-order channel flag
//   frame_count        : frames published, wraps modulo 2^32
module shim_abs_sample_concat
    import shim_sample_pkg::*;
#(
    parameter int unsigned N_CHANNELS   = N_CHANNELS_DEF,
    parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int unsigned ABS_WIDTH    = ABS_WIDTH_DEF
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             enable,
    input  logic                             sample_valid,
    input  logic [SAMPLE_WIDTH-1:0]          sample_data,
    input  logic [CHAN_WIDTH-1:0]            sample_channel,
    output logic                             sample_ready,
    output logic [N_CHANNELS*ABS_WIDTH-1:0]  abs_sample_concat,
    output logic                             concat_valid,
    output logic                             err_sequence,
    output logic [31:0]                      frame_count
);

    localparam logic [CHAN_WIDTH-1:0] LAST_CH = CHAN_WIDTH'(N_CHANNELS - 1);

    state_t                          state, state_nxt;
    logic [CHAN_WIDTH-1:0]           exp_chan;
    logic                            hs, chan_ok, stay;
    logic [ABS_WIDTH-1:0]            abs_val;

    logic                            s1_valid;
    logic [ABS_WIDTH-1:0]            s1_abs;
    logic [CHAN_WIDTH-1:0]           s1_chan;
    logic                            s2_pub;
    logic [N_CHANNELS*ABS_WIDTH-1:0] shadow;
    logic [31:0]                     frame_cnt;

    assign frame_count = frame_cnt;

    shim_abs_sat #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .ABS_WIDTH    (ABS_WIDTH)
    ) u_abs_sat (
        .sample  (sample_data),
        .abs_val (abs_val)
    );

    always_comb begin
        state_nxt    = state;
        sample_ready = (state == ST_COLLECT);
        hs           = sample_valid & sample_ready;
        chan_ok      = (sample_channel == exp_chan);
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_COLLECT;
            end
            ST_COLLECT: begin
                // A bad channel wins over a simultaneous enable drop.
                if (hs && !chan_ok)  state_nxt = ST_ERROR;
                else if (!enable)    state_nxt = ST_IDLE;
            end
            ST_ERROR: state_nxt = ST_ERROR;
            default:  state_nxt = ST_IDLE;
        endcase
        // Pipeline stages only advance while collection continues across the
        // edge, so any beat in flight dies when we drop to idle or error.
        stay = (state == ST_COLLECT) && (state_nxt == ST_COLLECT);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state             <= ST_IDLE;
            exp_chan          <= '0;
            s1_valid          <= 1'b0;
            s1_abs            <= '0;
            s1_chan           <= '0;
            s2_pub            <= 1'b0;
            shadow            <= '0;
            abs_sample_concat <= '0;
            concat_valid      <= 1'b0;
            err_sequence      <= 1'b0;
            frame_cnt         <= '0;
        end else begin
            state        <= state_nxt;
            concat_valid <= 1'b0;

            if (state_nxt == ST_ERROR) err_sequence <= 1'b1;

            if (state != ST_COLLECT) begin
                exp_chan <= '0;
            end else if (hs) begin
                exp_chan <= (exp_chan == LAST_CH) ? '0 : exp_chan + CHAN_WIDTH'(1);
            end

            // Stage 1: register the converted beat.
            s1_valid <= hs & stay;
            if (hs) begin
                s1_abs  <= abs_val;
                s1_chan <= sample_channel;
            end

            // Stage 2: land it in its shadow lane; flag a frame-closing lane.
            if (s1_valid && stay) begin
                shadow[int'(s1_chan)*ABS_WIDTH +: ABS_WIDTH] <= s1_abs;
            end
            s2_pub <= s1_valid & stay & (s1_chan == LAST_CH);

            // Stage 3: publish. The shadow write of the next frame's first
            // lane may share this edge; non-blocking reads keep the old frame.
            if (s2_pub && stay) begin
                abs_sample_concat <= shadow;
                concat_valid      <= 1'b1;
                frame_cnt         <= frame_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_shim_abs_sample_concat.sv
module tb_shim_abs_sample_concat;

    localparam int N  = 8;
    localparam int SW = 16;
    localparam int AW = 15;

    logic           clk = 1'b0;
    logic           resetn = 1'b1;
    logic           enable = 1'b0;
    logic           sample_valid = 1'b0;
    logic [SW-1:0]  sample_data = '0;
    logic [2:0]     sample_channel = '0;
    logic           sample_ready;
    logic [N*AW-1:0] abs_sample_concat;
    logic           concat_valid;
    logic           err_sequence;
    logic [31:0]    frame_count;

    always #5 clk = ~clk;

    shim_abs_sample_concat #(
        .N_CHANNELS   (N),
        .SAMPLE_WIDTH (SW),
        .ABS_WIDTH    (AW)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .enable            (enable),
        .sample_valid      (sample_valid),
        .sample_data       (sample_data),
        .sample_channel    (sample_channel),
        .sample_ready      (sample_ready),
        .abs_sample_concat (abs_sample_concat),
        .concat_valid      (concat_valid),
        .err_sequence      (err_sequence),
        .frame_count       (frame_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic checkw(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_COLLECT, M_ERROR} mmode_t;
    typedef struct {
        int              due;
        logic [N*AW-1:0] data;
    } pub_t;

    mmode_t          m_mode = M_IDLE;
    int              m_exp = 0;
    int              m_lane [N];
    logic [N*AW-1:0] m_concat = '0;
    logic [31:0]     m_count = '0;
    logic            m_err = 1'b0;
    logic            m_pulse = 1'b0;
    int              edge_n = 0;
    pub_t            pend[$];

    function automatic int abs_sat(input logic [SW-1:0] d);
        int v;
        v = int'($signed(d));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    always @(posedge clk or negedge resetn) begin
        bit              leave;
        logic [N*AW-1:0] f;
        if (!resetn) begin
            m_mode   = M_IDLE;
            m_exp    = 0;
            m_concat = '0;
            m_count  = '0;
            m_err    = 1'b0;
            m_pulse  = 1'b0;
            edge_n   = 0;
            pend.delete();
        end else begin
            edge_n++;
            m_pulse = 1'b0;
            leave   = 1'b0;
            case (m_mode)
                M_IDLE: if (enable) begin
                    m_mode = M_COLLECT;
                    m_exp  = 0;
                end
                M_COLLECT: begin
                    if (sample_valid && int'(sample_channel) != m_exp) begin
                        m_mode = M_ERROR;
                        m_err  = 1'b1;
                        leave  = 1'b1;
                    end else if (!enable) begin
                        m_mode = M_IDLE;
                        leave  = 1'b1;
                    end else if (sample_valid) begin
                        m_lane[m_exp] = abs_sat(sample_data);
                        if (m_exp == N - 1) begin
                            for (int i = 0; i < N; i++) f[i*AW +: AW] = AW'(m_lane[i]);
                            pend.push_back('{due: edge_n + 2, data: f});
                        end
                        m_exp = (m_exp + 1) % N;
                    end
                end
                default: ;
            endcase
            if (leave) pend.delete();
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                m_concat = pend[0].data;
                m_count  = m_count + 32'd1;
                m_pulse  = 1'b1;
                void'(pend.pop_front());
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (resetn) begin
            check1("ready", sample_ready, m_mode == M_COLLECT);
            check1("concat_valid", concat_valid, m_pulse);
            check1("err_sequence", err_sequence, m_err);
            checkw("abs_sample_concat", 128'(abs_sample_concat), 128'(m_concat));
            checkw("frame_count", 128'(frame_count), 128'(m_count));
            if (concat_valid) pulses++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic beat(input logic [2:0] ch, input logic [SW-1:0] d);
        sample_valid   = 1'b1;
        sample_channel = ch;
        sample_data    = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    logic [SW-1:0]   f35 [N];
    logic [N*AW-1:0] exp_w;
    int              p0;

    initial begin
        f35 = '{16'h0064, 16'hFF9C, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFB, 16'h0007};

        // Reset state
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check1("rst_ready", sample_ready, 1'b0);
        check1("rst_valid", concat_valid, 1'b0);
        check1("rst_err", err_sequence, 1'b0);
        checkw("rst_concat", 128'(abs_sample_concat), 128'(0));
        checkw("rst_count", 128'(frame_count), 128'(0));
        resetn = 1'b1;
        idle(1);

        // Mixed-sign frame, back-to-back beats
        enable = 1'b1;
        idle(1);
        check1("collect_ready", sample_ready, 1'b1);
        for (int i = 0; i < N; i++) beat(3'(i), f35[i]);
        sample_valid = 1'b0;
        @(negedge clk);
        check1("pulse_not_early", concat_valid, 1'b0);
        @(negedge clk);
        check1("pulse_e2", concat_valid, 1'b1);
        exp_w = {15'd7, 15'd5, 15'd32767, 15'd32767, 15'd1, 15'd0, 15'd100, 15'd100};
        checkw("frame1_lanes", 128'(abs_sample_concat), 128'(exp_w));
        checkw("frame1_count", 128'(frame_count), 128'(1));
        @(negedge clk);
        check1("pulse_one_cycle", concat_valid, 1'b0);

        // Partial frame discarded by enable drop
        p0 = pulses;
        for (int i = 0; i < 4; i++) beat(3'(i), 16'd9);
        enable = 1'b0;
        idle(1);
        enable = 1'b1;
        idle(1);
        for (int i = 0; i < N; i++) beat(3'(i), 16'd50);
        idle(4);
        checkw("reenable_pulses", 128'(pulses - p0), 128'(1));
        for (int i = 0; i < N; i++) exp_w[i*AW +: AW] = 15'd50;
        checkw("reenable_lanes", 128'(abs_sample_concat), 128'(exp_w));
        checkw("reenable_count", 128'(frame_count), 128'(2));

        // Three frames with random gaps
        p0 = pulses;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) begin
                idle($urandom_range(0, 5));
                beat(3'(i), SW'($urandom));
            end
        end
        idle(4);
        checkw("gap_pulses", 128'(pulses - p0), 128'(3));
        checkw("gap_count", 128'(frame_count), 128'(5));

        // Asynchronous reset after ch6
        for (int i = 0; i < 7; i++) beat(3'(i), 16'd1234);
        sample_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check1("arst_ready", sample_ready, 1'b0);
        check1("arst_valid", concat_valid, 1'b0);
        check1("arst_err", err_sequence, 1'b0);
        checkw("arst_concat", 128'(abs_sample_concat), 128'(0));
        checkw("arst_count", 128'(frame_count), 128'(0));
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        p0 = pulses;
        idle(10);
        checkw("arst_no_pulse", 128'(pulses - p0), 128'(0));

        // frame_count wrap
        #2 force dut.frame_cnt = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        #1 release dut.frame_cnt;
        @(negedge clk);
        for (int i = 0; i < N; i++) beat(3'(i), 16'(i * 3));
        idle(3);
        checkw("wrap_zero", 128'(frame_count), 128'(0));
        for (int i = 0; i < N; i++) beat(3'(i), 16'(i * 5));
        idle(3);
        checkw("wrap_one", 128'(frame_count), 128'(1));

        // Out-of-order channel
        p0 = pulses;
        beat(3'd0, 16'd11);
        beat(3'd1, 16'd22);
        beat(3'd3, 16'd33);
        check1("seq_err_set", err_sequence, 1'b1);
        check1("seq_ready_low", sample_ready, 1'b0);
        for (int k = 0; k < 4; k++) begin
            enable = k[0];
            beat(3'(k), 16'd44);
        end
        enable = 1'b1;
        idle(5);
        checkw("seq_no_pulse", 128'(pulses - p0), 128'(0));
        check1("seq_err_sticky", err_sequence, 1'b1);
        check1("seq_ready_stuck", sample_ready, 1'b0);
        checkw("seq_count_hold", 128'(frame_count), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
